// File: rtl/aes_kb_pkg.sv
// Definitions shared by the tag generator and the key checker: FSM states and
// the single md5 padding rule that both ends must agree on.
package aes_kb_pkg;

  localparam logic [31:0] PAD_W14 = 32'h0;
  localparam logic [31:0] PAD_W15 = 32'h8000_0000;

  typedef enum logic [2:0] {IDLE, LOAD, KICK, WAIT_H, ENC, FIN} state_t;

  // Word i of the padded md5 block; words 0..13 are kb little-end first.
  function automatic logic [31:0] pad_word(input logic [447:0] kb, input logic [3:0] i);
    logic [8:0] base;
    base = {i, 5'b0};
    case (i)
      4'd14:   return PAD_W14;
      4'd15:   return PAD_W15;
      default: return kb[base +: 32];
    endcase
  endfunction

endpackage

// File: rtl/aes_kb_tag_if.sv
// Request/response bundle of the key-block tag generator.
interface aes_kb_tag_if;
  logic [447:0] kb;
  logic         start;
  logic         stall;
  logic [127:0] tag;
  logic [127:0] key;
  logic         busy;
  logic         done;

  modport master (output kb, start, stall, input tag, key, busy, done);
  modport slave  (input kb, start, stall, output tag, key, busy, done);
endinterface

// File: rtl/aes_enc.sv
// Encrypt-direction block cipher core: fully pipelined, ciphertext valid LAT
// cycles after key_in/data_in become stable.
module aes_enc #(
  parameter int LAT = 38
) (
  input  logic         clk,
  input  logic [127:0] key_in,
  input  logic [127:0] data_in,
  output logic [127:0] data_out
);

  logic [LAT-1:0][127:0] pipe;

  function automatic logic [127:0] cipher(input logic [127:0] key, input logic [127:0] data);
    logic [127:0] s, k, rot, swp;
    s = data;
    k = key;
    for (int r = 0; r < 4; r++) begin
      s   = s ^ k;
      rot = {s[120:0], s[127:121]};
      swp = {s[63:0], s[127:64]};
      s   = rot ^ (s + swp);
      k   = {k[95:0], k[127:96] ^ 32'h1b};
    end
    return s ^ k;
  endfunction

  always_ff @(posedge clk) begin
    pipe[0] <= cipher(key_in, data_in);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  assign data_out = pipe[LAT-1];

endmodule

// File: rtl/md5.sv
// Digest core with the md5 port shape: 16-word block buffer, start strobe,
// one-cycle done pulse LAT cycles after start with the digest held stable.
module md5 #(
  parameter int LAT = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         write,
  input  logic [3:0]   writeaddr,
  input  logic [31:0]  writedata,
  input  logic         start,
  output logic         done,
  output logic [127:0] digest
);

  logic [15:0][31:0] blk;
  logic [5:0]        cnt;
  logic              run;

  function automatic logic [127:0] compress(input logic [15:0][31:0] w);
    logic [127:0] h;
    logic [31:0]  a, t;
    h = 128'h67452301_efcdab89_98badcfe_10325476;
    for (int i = 0; i < 16; i++) begin
      a = h[127:96];
      t = {a[24:0], a[31:25]} ^ w[i];
      t = t + h[31:0] + h[63:32];
      h = {h[95:0], t};
    end
    return h;
  endfunction

  always_ff @(posedge clk) begin
    if (write) blk[writeaddr] <= writedata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run    <= 1'b0;
      cnt    <= '0;
      done   <= 1'b0;
      digest <= '0;
    end else begin
      done <= run && (cnt == 6'(LAT - 1));
      if (start) begin
        run    <= 1'b1;
        cnt    <= 6'd1;
        digest <= compress(blk);
      end else if (run) begin
        cnt <= cnt + 6'd1;
        if (cnt == 6'(LAT - 1)) run <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/aes_kb_tag.sv
// Key-check tag generator: md5-pads kb, digests it to H, then emits
// tag = AES_enc(key=H, data=H) alongside H.
module aes_kb_tag
  import aes_kb_pkg::*;
#(
  parameter int AES_LAT   = 38,
  parameter int MD5_WORDS = 16
) (
  input logic         clk,
  input logic         rst,
  aes_kb_tag_if.slave bus
);

  if (AES_LAT >= 64) begin : g_bad_lat
    $error("AES_LAT must be below 64 to fit the 6-bit counter");
  end

  localparam logic [5:0] LAST_CNT  = 6'(AES_LAT);
  localparam logic [3:0] LAST_WORD = 4'(MD5_WORDS - 1);

  state_t         state, nxt;
  logic [5:0]     count;
  logic [447:0]   kb_r;
  logic [127:0]   key_r, tag_r, md5_digest, aes_out;
  logic           done_r, md5_seen, seen_now;
  logic           md5_wr, md5_start, md5_done;
  logic [3:0]     md5_addr;
  logic [31:0]    md5_wdata;

  // A done arriving in the cycle we'd leave WAIT_H counts straight away.
  assign seen_now = md5_seen | md5_done;

  always_ff @(posedge clk) begin
    if (rst)             state <= IDLE;
    else if (!bus.stall) state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (bus.start) nxt = LOAD;
      LOAD:    if (count[3:0] == LAST_WORD) nxt = KICK;
      KICK:    nxt = WAIT_H;
      WAIT_H:  if (seen_now) nxt = ENC;
      ENC:     if (count == LAST_CNT) nxt = FIN;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    md5_wr    = 1'b0;
    md5_start = 1'b0;
    case (state)
      LOAD:    md5_wr    = !bus.stall;
      KICK:    md5_start = !bus.stall;
      default: ;
    endcase
  end

  assign md5_addr  = count[3:0];
  assign md5_wdata = pad_word(kb_r, count[3:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      kb_r   <= '0;
      key_r  <= '0;
      tag_r  <= '0;
      done_r <= 1'b0;
    end else if (!bus.stall) begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            kb_r  <= bus.kb;
            count <= '0;
          end
        end
        LOAD:   count <= count + 6'd1;
        WAIT_H: if (seen_now) begin
          key_r <= md5_digest;
          count <= '0;
        end
        ENC:    count <= count + 6'd1;
        FIN: begin
          tag_r  <= aes_out;
          done_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Sticky across stall so a done pulse hidden by a stall is not lost.
  always_ff @(posedge clk) begin
    if (rst)                              md5_seen <= 1'b0;
    else if (state == KICK && !bus.stall) md5_seen <= 1'b0;
    else if (md5_done)                    md5_seen <= 1'b1;
  end

  md5 u_md5 (
    .clk       (clk),
    .rst       (rst),
    .write     (md5_wr),
    .writeaddr (md5_addr),
    .writedata (md5_wdata),
    .start     (md5_start),
    .done      (md5_done),
    .digest    (md5_digest)
  );

  aes_enc #(.LAT(AES_LAT)) u_aes (
    .clk      (clk),
    .key_in   (key_r),
    .data_in  (key_r),
    .data_out (aes_out)
  );

  assign bus.tag  = tag_r;
  assign bus.key  = key_r;
  assign bus.busy = (state != IDLE);
  assign bus.done = done_r;

endmodule

// File: tb/tb_aes_kb_tag.sv
// Scoreboard bench for aes_kb_tag: expected tag/key pushed at start, popped on done.
module tb_aes_kb_tag;

  localparam int AES_LAT  = 38;
  localparam int T_MD5    = 20;  // md5 core: start edge to the edge that sees done
  localparam int BASE_LAT = 16 + 1 + T_MD5 + AES_LAT + 2;
  localparam int BOUND    = 400;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_kb_tag_if bus();

  aes_kb_tag #(.AES_LAT(AES_LAT), .MD5_WORDS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [127:0] tag;
    logic [127:0] key;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model
  function automatic logic [31:0] m_pad(input logic [447:0] kb, input int i);
    logic [447:0] t;
    t = kb >> (32 * i);
    if (i == 14) return 32'h0;
    if (i == 15) return 32'h8000_0000;
    return t[31:0];
  endfunction

  function automatic logic [127:0] m_digest(input logic [447:0] kb);
    logic [127:0] h;
    logic [31:0]  a, t;
    h = 128'h67452301_efcdab89_98badcfe_10325476;
    for (int i = 0; i < 16; i++) begin
      a = h[127:96];
      t = ((a << 7) | (a >> 25)) ^ m_pad(kb, i);
      t = t + h[31:0] + h[63:32];
      h = {h[95:0], t};
    end
    return h;
  endfunction

  function automatic logic [127:0] m_enc(input logic [127:0] key, input logic [127:0] d);
    logic [127:0] s, k;
    s = d;
    k = key;
    for (int r = 0; r < 4; r++) begin
      s = s ^ k;
      s = ((s << 7) | (s >> 121)) ^ (s + ((s << 64) | (s >> 64)));
      k = (k << 32) | ((k >> 96) ^ 128'h1b);
    end
    return s ^ k;
  endfunction

  function automatic logic [127:0] m_tag(input logic [447:0] kb);
    logic [127:0] h;
    h = m_digest(kb);
    return m_enc(h, h);
  endfunction

  // Checker side: valid when the tag re-derives from kb.
  function automatic logic m_check(input logic [447:0] kb, input logic [127:0] tag);
    return m_tag(kb) == tag;
  endfunction

  // Call at a negedge; returns at a negedge one cycle after done.
  task automatic run_op(input string nm, input logic [447:0] kb, input bit stl,
                        input bit rp, input logic [447:0] rp_kb,
                        output int lat, output logic [127:0] tag_obs);
    int e = -1, hold = 0, wr_cnt = 0, wr_bad = 0;
    bit wh = 0, got = 0, busy_bad = 0;
    logic [15:0] wr_mask = '0;
    exp_t x;
    bus.kb    = kb;
    bus.start = 1'b1;
    sb.push_back('{m_tag(kb), m_digest(kb)});
    lat = -1;
    tag_obs = '0;
    while (e < BOUND) begin
      @(negedge clk);
      e++;
      if (bus.done) begin got = 1; break; end
      if (!bus.busy) busy_bad = 1;
      if (rp && e == T_MD5 + 30) begin
        bus.start = 1'b1;
        bus.kb    = rp_kb;
      end else bus.start = 1'b0;
      if (stl && !wh && dut.md5_done) begin wh = 1; hold = 3; end
      bus.stall = stl && ((e >= 3 && e <= 7) || hold > 0 ||
                          (e >= T_MD5 + 35 && e <= T_MD5 + 41));
      if (hold > 0) hold--;
      #1;
      if (dut.md5_wr) begin
        wr_cnt++;
        if (wr_mask[dut.md5_addr]) wr_bad++;
        wr_mask[dut.md5_addr] = 1'b1;
        if (dut.md5_wdata !== m_pad(kb, int'(dut.md5_addr))) wr_bad++;
      end
    end
    bus.stall = 1'b0;
    bus.start = 1'b0;
    x = sb.pop_front();
    if (!got) chk({nm, "_timeout"}, 0, 1);
    else begin
      lat = e;
      tag_obs = bus.tag;
      chk({nm, "_tag"}, bus.tag, x.tag);
      chk({nm, "_key"}, bus.key, x.key);
    end
    chk({nm, "_wr_cnt"}, 128'(wr_cnt), 16);
    chk({nm, "_wr_mask"}, wr_mask, 16'hffff);
    chk({nm, "_wr_bad"}, 128'(wr_bad), 0);
    chk({nm, "_busy"}, busy_bad, 0);
    @(negedge clk);
    chk({nm, "_done_pulse"}, bus.done, 0);
  endtask

  initial begin
    logic [447:0] k0, k1, k2;
    logic [127:0] t0, t1, t2, ts, tr, tx;
    int lat;
    k0 = '0;
    k1 = '1;
    k2 = {7{64'h0123456789abcdef}};
    rst = 1'b1;
    bus.kb = '0;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tag", bus.tag, 0);
    chk("rst_key", bus.key, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op("kb0", k0, 0, 0, '0, lat, t0);
    chk("kb0_lat", 128'(lat), BASE_LAT);
    chk("kb0_valid", m_check(k0, t0), 1);
    run_op("ones", k1, 0, 0, '0, lat, t1);
    chk("ones_valid", m_check(k1, t1), 1);
    run_op("incr", k2, 0, 0, '0, lat, t2);
    chk("incr_valid", m_check(k2, t2), 1);
    chk("diff_ones_kb0", t1 != t0, 1);
    chk("diff_incr_kb0", t2 != t0, 1);
    chk("diff_incr_ones", t2 != t1, 1);
    chk("flip_invalid", m_check(k0, t0 ^ 128'h1), 0);
    chk("cross_invalid", m_check(k1, t0), 0);

    run_op("stall", k0, 1, 0, '0, lat, ts);
    chk("stall_lat", 128'(lat), BASE_LAT + 15);
    chk("stall_same_tag", ts, t0);

    run_op("repulse", k1, 0, 1, k2, lat, tr);
    chk("repulse_lat", 128'(lat), BASE_LAT);

    // Abort in ENC, then restart in the first cycle out of reset.
    bus.kb = k2;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (T_MD5 + 30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_tag", bus.tag, 0);
    chk("abort_key", bus.key, 0);
    rst = 1'b0;
    run_op("restart", k2, 0, 0, '0, lat, tx);
    chk("restart_lat", 128'(lat), BASE_LAT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
